// File: rtl/fm_pkg.sv
// fm_pkg: shared envelope phase type, register selects and attenuation helpers
package fm_pkg;
   typedef enum logic [2:0] {PH_IDLE, PH_ATTACK, PH_DECAY, PH_SUSTAIN, PH_RELEASE} phase_t;
   localparam logic [1:0] SEL_KEY = 2'd0;
   localparam logic [1:0] SEL_ADR = 2'd1;
   localparam logic [1:0] SEL_SLR = 2'd2;
   function automatic int unsigned att_max(int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction
   function automatic int unsigned sl_level(logic [3:0] sl, int unsigned w);
      return 32'(sl) << (w - 4);
   endfunction
endpackage

// File: rtl/fm_env_step.sv
// fm_env_step: next phase/attenuation for one envelope slot.
// FM_ENV_EXP_ATTACK_EN selects exponential attack instead of linear -4 steps.
module fm_env_step
   import fm_pkg::*;
#(
   parameter int ENV_W = 10
) (
   input  phase_t           phase,
   input  logic [ENV_W-1:0] att,
   input  logic             key,
   input  logic [3:0]       ar,
   input  logic [3:0]       dr,
   input  logic [3:0]       rr,
   input  logic [3:0]       sl,
   input  logic [15:0]      env_cnt,
   output phase_t           phase_nx,
   output logic [ENV_W-1:0] att_nx
);
   localparam logic [ENV_W-1:0] MAX = ENV_W'(att_max(ENV_W));
   phase_t ph_k;
   logic [ENV_W-1:0] dec, att_inc, sl_att;
   // rate r ticks when the low 15-r bits of env_cnt are all zero
   function automatic logic tick(logic [3:0] r, logic [15:0] cnt);
      return r != 4'd0 && (cnt & ((16'd1 << (4'd15 - r)) - 16'd1)) == 16'd0;
   endfunction
   always_comb begin
      ph_k = (key && (phase == PH_IDLE || phase == PH_RELEASE)) ? PH_ATTACK :
             (!key && (phase == PH_ATTACK || phase == PH_DECAY || phase == PH_SUSTAIN)) ? PH_RELEASE : phase;
`ifdef FM_ENV_EXP_ATTACK_EN
      dec = (att >> 3) + ENV_W'(1);
`else
      dec = ENV_W'(4);
`endif
      att_inc = (att == MAX) ? MAX : att + ENV_W'(1);
      sl_att = ENV_W'(sl_level(sl, ENV_W));
      phase_nx = ph_k;
      att_nx = att;
      case (ph_k)
         PH_ATTACK: if (tick(ar, env_cnt)) begin
            att_nx = (att > dec) ? att - dec : '0;
            phase_nx = (att > dec) ? PH_ATTACK : PH_DECAY;
         end
         PH_DECAY: if (tick(dr, env_cnt)) begin
            att_nx = att_inc;
            phase_nx = (att_inc >= sl_att) ? PH_SUSTAIN : PH_DECAY;
         end
         PH_RELEASE: if (tick(rr, env_cnt)) begin
            att_nx = att_inc;
            phase_nx = (att_inc == MAX) ? PH_IDLE : PH_RELEASE;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/fm_env_gen.sv
// fm_env_gen: time-multiplexed ADSR envelope generator, one channel per cycle per sample.
// FM_ENV_EXP_ATTACK_EN (in fm_env_step) selects exponential attack.
module fm_env_gen
   import fm_pkg::*;
#(
   parameter int NUM_CH = 32,
   parameter int ENV_W = 10,
   localparam int CH_W = $clog2(NUM_CH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_start,
   input  logic             reg_wr,
   input  logic [CH_W-1:0]  reg_ch,
   input  logic [1:0]       reg_sel,
   input  logic [7:0]       reg_wrdata,
   output logic             busy,
   output logic             env_valid,
   output logic [CH_W-1:0]  env_ch,
   output logic [ENV_W-1:0] env_att
);
   localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
   logic key_r [NUM_CH];
   logic [3:0] ar_r [NUM_CH];
   logic [3:0] dr_r [NUM_CH];
   logic [3:0] sl_r [NUM_CH];
   logic [3:0] rr_r [NUM_CH];
   phase_t ph_m [NUM_CH];
   logic [ENV_W-1:0] att_m [NUM_CH];
   logic rd_act;
   logic [CH_W-1:0] rd_ch;
   logic [15:0] env_cnt;
   phase_t ph_nx;
   logic [ENV_W-1:0] att_nx;
   assign busy = rd_act | env_valid;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            key_r[i] <= 1'b0;
            ar_r[i] <= '0;
            dr_r[i] <= '0;
            sl_r[i] <= '0;
            rr_r[i] <= '0;
         end
      end else if (reg_wr) begin
         if (reg_sel == SEL_KEY) key_r[reg_ch] <= reg_wrdata[0];
         if (reg_sel == SEL_ADR) {ar_r[reg_ch], dr_r[reg_ch]} <= reg_wrdata;
         if (reg_sel == SEL_SLR) {sl_r[reg_ch], rr_r[reg_ch]} <= reg_wrdata;
      end
   end
   fm_env_step #(.ENV_W(ENV_W)) u_step (
      .phase(ph_m[rd_ch]), .att(att_m[rd_ch]), .key(key_r[rd_ch]),
      .ar(ar_r[rd_ch]), .dr(dr_r[rd_ch]), .rr(rr_r[rd_ch]), .sl(sl_r[rd_ch]),
      .env_cnt(env_cnt), .phase_nx(ph_nx), .att_nx(att_nx)
   );
   // slot read and step happen in the read cycle; write-back and outputs land on its closing edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_act <= 1'b0;
         rd_ch <= '0;
         env_valid <= 1'b0;
         env_ch <= '0;
         env_att <= '0;
         env_cnt <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            ph_m[i] <= PH_IDLE;
            att_m[i] <= ENV_W'(att_max(ENV_W));
         end
      end else begin
         env_valid <= rd_act;
         if (rd_act) begin
            ph_m[rd_ch] <= ph_nx;
            att_m[rd_ch] <= att_nx;
            env_ch <= rd_ch;
            env_att <= att_nx;
            rd_act <= rd_ch != LAST;
            rd_ch <= (rd_ch == LAST) ? '0 : rd_ch + CH_W'(1);
         end else if (sample_start && !busy) begin
            rd_act <= 1'b1;
            rd_ch <= '0;
         end
         if (env_valid && env_ch == LAST) env_cnt <= env_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_fm_env_gen.sv
// tb_fm_env_gen: directed sweeps checked against a queue-based envelope scoreboard.
// Honours FM_ENV_EXP_ATTACK_EN in its reference model.
module tb_fm_env_gen;
   localparam int N = 4, W = 10, MX = 1023;
   localparam int IDLE = 0, ATK = 1, DEC = 2, SUS = 3, REL = 4;
   typedef struct {int ch; int att;} exp_t;
   logic clk = 1'b0, reset = 1'b1, sample_start = 1'b0, reg_wr = 1'b0;
   logic [1:0] reg_ch = '0, reg_sel = '0;
   logic [7:0] reg_wrdata = '0;
   logic busy, env_valid;
   logic [1:0] env_ch;
   logic [9:0] env_att;
   int total = 0, bad = 0, nvalid = 0, n;
   int last_att [N];
   int m_key [N], m_ar [N], m_dr [N], m_sl [N], m_rr [N], m_ph [N], m_att [N];
   int m_cnt;
   exp_t q [$];
   exp_t e;

   fm_env_gen #(.NUM_CH(N), .ENV_W(W)) dut (
      .clk(clk), .reset(reset), .sample_start(sample_start), .reg_wr(reg_wr),
      .reg_ch(reg_ch), .reg_sel(reg_sel), .reg_wrdata(reg_wrdata),
      .busy(busy), .env_valid(env_valid), .env_ch(env_ch), .env_att(env_att)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic bit tk(int r);
      return r != 0 && (m_cnt % (1 << (15 - r))) == 0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_key[c] = 0; m_ar[c] = 0; m_dr[c] = 0; m_sl[c] = 0; m_rr[c] = 0;
         m_ph[c] = IDLE; m_att[c] = MX;
      end
      m_cnt = 0;
      q.delete();
   endtask

   task automatic model_write(input int ch, input int sel, input int d);
      if (sel == 0) m_key[ch] = d % 2;
      if (sel == 1) begin m_ar[ch] = d / 16; m_dr[ch] = d % 16; end
      if (sel == 2) begin m_sl[ch] = d / 16; m_rr[ch] = d % 16; end
   endtask

   task automatic model_sweep();
      int dec;
      for (int c = 0; c < N; c++) begin
         if (m_key[c] == 1 && (m_ph[c] == IDLE || m_ph[c] == REL)) m_ph[c] = ATK;
         else if (m_key[c] == 0 && (m_ph[c] == ATK || m_ph[c] == DEC || m_ph[c] == SUS)) m_ph[c] = REL;
`ifdef FM_ENV_EXP_ATTACK_EN
         dec = m_att[c] / 8 + 1;
`else
         dec = 4;
`endif
         if (m_ph[c] == ATK && tk(m_ar[c])) begin
            m_att[c] = (m_att[c] - dec < 0) ? 0 : m_att[c] - dec;
            if (m_att[c] == 0) m_ph[c] = DEC;
         end else if (m_ph[c] == DEC && tk(m_dr[c])) begin
            if (m_att[c] < MX) m_att[c]++;
            if (m_att[c] >= m_sl[c] * 64) m_ph[c] = SUS;
         end else if (m_ph[c] == REL && tk(m_rr[c])) begin
            if (m_att[c] < MX) m_att[c]++;
            if (m_att[c] == MX) m_ph[c] = IDLE;
         end
         q.push_back('{c, m_att[c]});
      end
      m_cnt = (m_cnt + 1) % 65536;
   endtask

   task automatic wr(input int ch, input int sel, input int d);
      @(negedge clk);
      reg_wr = 1'b1; reg_ch = 2'(ch); reg_sel = 2'(sel); reg_wrdata = 8'(d);
      model_write(ch, sel, d);
      @(negedge clk);
      reg_wr = 1'b0;
   endtask

   // optional mid-sweep sample_start pulse and a register write during ch0's slot
   task automatic do_sweep(input bit mid_ss, input bit w, input int wch, input int wsel, input int wdat);
      int nb = 0;
      if (w) model_write(wch, wsel, wdat);
      model_sweep();
      nvalid = 0;
      @(negedge clk);
      sample_start = 1'b1;
      @(negedge clk);
      sample_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         nb += busy ? 1 : 0;
         if (i == 0 && w) begin
            reg_wr = 1'b1; reg_ch = 2'(wch); reg_sel = 2'(wsel); reg_wrdata = 8'(wdat);
         end
         if (i == 1) begin reg_wr = 1'b0; sample_start = mid_ss; end
         if (i == 2) sample_start = 1'b0;
         @(negedge clk);
      end
      chk("busy_cycles", nb, N + 1);
      chk("valid_count", nvalid, N);
   endtask

   task automatic sweep();
      do_sweep(1'b0, 1'b0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (env_valid === 1'b1) begin
         nvalid++;
         chk("expect_pending", q.size() > 0, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("env_ch", env_ch, e.ch);
            chk("env_att", env_att, e.att);
            last_att[env_ch] = int'(env_att);
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", env_valid, 0);
      chk("rst_ch", env_ch, 0);
      chk("rst_att", env_att, 0);
      reset = 1'b0;
      sweep();
      // linear attack on ch2 down to 0, then hold in decay with DR=0
      wr(2, 1, 'hF0); wr(2, 0, 1);
      repeat (256) sweep();
      chk("ch2_att_zero", last_att[2], 0);
      repeat (3) sweep();
      chk("ch2_att_hold", last_att[2], 0);
      // ch1 full ADS, ch0 decays on even env_cnt only, ch3 attacks to 0
      wr(1, 1, 'hFF); wr(1, 2, 'h80); wr(1, 0, 1);
      wr(0, 1, 'hFE); wr(0, 2, 'hF0); wr(0, 0, 1);
      wr(3, 1, 'hF0); wr(3, 0, 1);
      n = 0;
      while (m_ph[1] != SUS && n < 2000) begin sweep(); n++; end
      chk("ch1_sustain_att", last_att[1], 512);
      repeat (4) sweep();
      chk("ch1_sustain_hold", last_att[1], 512);
      wr(1, 2, 'h8F); wr(1, 0, 0);
      n = 0;
      while (m_ph[1] != IDLE && n < 2000) begin sweep(); n++; end
      chk("ch1_release_max", last_att[1], MX);
      repeat (3) sweep();
      chk("ch1_idle_max", last_att[1], MX);
      // release ch3 up to 700, then retrigger from that level
      wr(3, 2, 'h0F); wr(3, 0, 0);
      n = 0;
      while (m_att[3] != 700 && n < 2000) begin sweep(); n++; end
      chk("ch3_at_700", last_att[3], 700);
      wr(3, 0, 1);
      sweep();
      chk("ch3_retrigger", last_att[3], 696);
      do_sweep(1'b1, 1'b1, 3, 0, 0);
      chk("ch3_same_sweep_write", last_att[3], 697);
      // reset in the middle of a sweep
      model_sweep();
      @(negedge clk);
      sample_start = 1'b1;
      @(negedge clk);
      sample_start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", env_valid, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      sweep();
      chk("post_rst_ch0", last_att[0], MX);
      chk("post_rst_ch3", last_att[3], MX);
      wr(2, 1, 'hF0); wr(2, 0, 1);
      repeat (10) sweep();
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fm_env_gen.md
# fm_env_gen

Parametrised, time-multiplexed ADSR envelope generator for the FM synthesizer: the successor to a fixed per-operator envelope, scaled in channel count and attenuation width. Once per audio sample it sweeps every channel in turn, advances that channel's envelope state and emits one attenuation value per channel. Its output stream feeds the operator/mixer pipeline that produces `audio_l`/`audio_r`. Registers are written from the fmsynth bus decoder.

## Interface
- `NUM_CH`, 32: number of envelope channels (≥2); `CH_W = $clog2(NUM_CH)`
- `ENV_W`, 10: attenuation width (≥6); 0 = loudest, `2^ENV_W-1` = silent (ATT_MAX)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `sample_start`  in  1  one-cycle pulse per audio sample; starts a sweep
- `reg_wr`  in  1  register write strobe
- `reg_ch`  in  CH_W  target channel
- `reg_sel`  in  2  0: KEY {bit0}; 1: {AR[7:4], DR[3:0]}; 2: {SL[7:4], RR[3:0]}; 3: ignored
- `reg_wrdata`  in  8  write data
- `busy`  out  1  sweep in progress
- `env_valid`  out  1  `env_ch`/`env_att` valid this cycle
- `env_ch`  out  CH_W  channel of emitted value
- `env_att`  out  ENV_W  attenuation of emitted value

## Operation
- Per-channel state: config (key, AR, DR, SL, RR) in flops; phase {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} plus att in state memory.
- Global 16-bit `env_cnt`, incremented once when each sweep completes; wraps 0xFFFF→0.
- Rate tick for rate r: r=0 never; else tick when `env_cnt[14-r:0] == 0` (r=15: every sample; r=14: every 2nd; r=1: every 2^14th).
- Key evaluation, at the channel's sweep slot, before stepping:
  - key=1 and phase IDLE/RELEASE → ATTACK, att kept (retrigger from current level).
  - key=0 and phase ATTACK/DECAY/SUSTAIN → RELEASE.
- Step, applied only on a rate tick of the phase's rate:
  - ATTACK (AR): att -= 4, saturating at 0; at 0 → DECAY.
  - DECAY (DR): att += 1; when att ≥ SL<<(ENV_W-4) → SUSTAIN.
  - SUSTAIN: hold, no rate.
  - RELEASE (RR): att += 1, saturating at ATT_MAX; at ATT_MAX → IDLE.
  - IDLE: att held.
- The emitted att is the post-step value.
- Register writes are accepted every cycle, busy or not.
  - A write to a channel not yet swept this sample takes effect in this sweep.
  - A write to a channel whose slot read is in the same cycle is seen next sweep (the read returns the old value).
- `sample_start` while `busy` is ignored; the sweep in progress is unaffected.

## Timing
- Two-stage pipeline: stage 1 reads state/config for ch k; stage 2 computes, writes back and registers outputs.
- If `sample_start` is high in cycle 0, ch k is read in cycle k+1 and `env_valid` is high in cycle k+2 with `env_ch`=k.
- `busy` is high in cycles 1..NUM_CH+1.
- `env_cnt` increments in the cycle after the last `env_valid`.
- Back-to-back sweeps: the earliest accepted next `sample_start` is in cycle NUM_CH+2.
- Reset values: `busy`=0, `env_valid`=0, `env_ch`=0, `env_att`=0, `env_cnt`=0, all phases IDLE, all att=ATT_MAX, all config 0.
- Reset asserted mid-sweep aborts immediately; no partial write-back survives.

## Configuration
- `FM_ENV_EXP_ATTACK_EN` defined: the ATTACK step is att -= (att>>3)+1, saturating at 0 (exponential attack).
- Not defined: linear attack, att -= 4. All other behaviour is identical.

## Structure
- Shared package `fm_pkg`: phase enum, `reg_sel` constants, ATT_MAX/SL-shift helper function.
- Sub-module `fm_env_step` holds the combinational next-phase/next-att computation (inputs phase, att, key, rates, SL, env_cnt). Instantiated once in stage 2.
- The top level holds the sweep counter, state memory, config registers and output registers.

## Test plan
- Reset, then `sample_start` with NUM_CH=4:
  - `env_valid` pulses 4 cycles with ch 0..3, all att=1023.
  - `busy` is high for 5 cycles.
- ch2 AR=15, DR=0, key=1 (linear attack):
  - After sweep n, att=1023-4n.
  - att reaches 0 at sweep 256, phase DECAY; att holds 0 thereafter.
- ch1 AR=15, DR=15, SL=8:
  - After attack, att rises 1 per sample to 512, then holds 512 (SUSTAIN).
  - Key=0, RR=15: att rises 1 per sample to 1023, then IDLE; further sweeps emit 1023.
- DR=14: att steps only on even `env_cnt`. A retriggered key=1 during RELEASE at att=700 restarts ATTACK from 700.
- `sample_start` pulsed mid-sweep is ignored (exactly NUM_CH `env_valid`). A write to ch3 during ch0's slot is seen in the same sweep.
- `reset` asserted at sweep cycle 2:
  - `busy`/`env_valid` are low the same cycle.
  - The next sweep emits 1023 for all channels.
- With `FM_ENV_EXP_ATTACK_EN`, AR=15 from 1023: the att sequence is 1023, 895, 783, 685, …, reaching 0.
